// File: rtl/mux_pkg.sv
// Shared constants for the pipelined N-way mux.
//   SEL_BINARY / SEL_ONEHOT : select encoding for the ONEHOT parameter
//   EMPTY / ONE / TWO       : buffer occupancy states of pipe_muxn
package mux_pkg;

    localparam int SEL_BINARY = 0;
    localparam int SEL_ONEHOT = 1;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t TWO   = 2'd2;

endpackage

// File: rtl/muxn.sv
// Combinational N-way selector with illegal-select detect.
//   d_i       : N flattened inputs, input k at [k*WIDTH +: WIDTH]
//   s_i       : select, binary or one-hot depending on ONEHOT
//   y_o       : selected input
//   illegal_o : select is out of range (binary) or not exactly one bit set (one-hot)
module muxn import mux_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int ONEHOT = SEL_BINARY,
    parameter int SW     = (ONEHOT == SEL_ONEHOT) ? N : $clog2(N)
) (
    input  logic [N*WIDTH-1:0] d_i,
    input  logic [SW-1:0]      s_i,
    output logic [WIDTH-1:0]   y_o,
    output logic               illegal_o
);

    if (ONEHOT == SEL_ONEHOT) begin : g_onehot
        // Scan from the top so the lowest set bit wins; no bit set falls back to d0.
        always_comb begin
            y_o = d_i[WIDTH-1:0];
            for (int k = N - 1; k >= 0; k--) begin
                if (s_i[k]) begin
                    y_o = d_i[k*WIDTH +: WIDTH];
                end
            end
            illegal_o = ($countones(s_i) != 1);
        end
    end else begin : g_binary
        // Anything at or beyond N-1 clamps to the last input.
        always_comb begin
            y_o       = d_i[(N-1)*WIDTH +: WIDTH];
            illegal_o = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (s_i == SW'(k)) begin
                    illegal_o = 1'b0;
                    if (k < N - 1) begin
                        y_o = d_i[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_muxn.sv
// Pipelined N-way mux with a 2-entry (main + skid) output buffer.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   d, s                : flattened data inputs and select for the current beat
//   in_valid, in_ready  : input handshake (in_ready is registered)
//   flush               : drop all buffered beats, including one accepted this cycle
//   y, out_valid        : oldest buffered beat (held while stalled)
//   out_ready           : downstream accepts y
//   sel_err             : sticky illegal-select flag, cleared only by reset
module pipe_muxn import mux_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int ONEHOT = SEL_BINARY,
    parameter int SW     = (ONEHOT == SEL_ONEHOT) ? N : $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SW-1:0]      s,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               sel_err_q, sel_err_d;
    logic               in_ready_q;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_illegal;
    logic               accept;

    muxn #(
        .WIDTH  (WIDTH),
        .N      (N),
        .ONEHOT (ONEHOT),
        .SW     (SW)
    ) u_muxn (
        .d_i       (d),
        .s_i       (s),
        .y_o       (sel_data),
        .illegal_o (sel_illegal)
    );

    // Masked by reset so the port reads 0 during reset yet 1 as soon as it drops.
    assign in_ready  = in_ready_q & ~reset;
    assign accept    = in_valid & in_ready;
    assign y         = main_q;
    assign out_valid = (state_q != EMPTY);
    assign sel_err   = sel_err_q;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = sel_err_q | (accept & sel_illegal);

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = sel_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    main_d = sel_data;
                end else if (accept) begin
                    skid_d  = sel_data;
                    state_d = TWO;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins: buffers keep their contents so y does not move while out_valid is low.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            sel_err_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            sel_err_q  <= sel_err_d;
            in_ready_q <= (state_d != TWO);
        end
    end

endmodule

// File: tb/tb_pipe_muxn.sv
// Self-checking bench for pipe_muxn: three instances (N=4 binary, N=3 binary, N=4 one-hot),
// a vector table of single beats, hand sequences for stall/flush/reset, and a random run
// on the N=3 instance against a queue-based reference model.
module tb_pipe_muxn;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic [1:0]  s4, s3;
    logic [3:0]  sh;
    logic        iv [3];
    logic        flush;
    logic        out_ready;
    logic [7:0]  y  [3];
    logic        ov [3];
    logic        ir [3];
    logic        er [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_muxn #(.WIDTH(8), .N(4), .ONEHOT(0)) u4 (
        .clk(clk), .reset(reset), .d(d), .s(s4), .in_valid(iv[0]), .in_ready(ir[0]),
        .flush(flush), .y(y[0]), .out_valid(ov[0]), .out_ready(out_ready), .sel_err(er[0])
    );
    pipe_muxn #(.WIDTH(8), .N(3), .ONEHOT(0)) u3 (
        .clk(clk), .reset(reset), .d(d[23:0]), .s(s3), .in_valid(iv[1]), .in_ready(ir[1]),
        .flush(flush), .y(y[1]), .out_valid(ov[1]), .out_ready(out_ready), .sel_err(er[1])
    );
    pipe_muxn #(.WIDTH(8), .N(4), .ONEHOT(1)) uh (
        .clk(clk), .reset(reset), .d(d), .s(sh), .in_valid(iv[2]), .in_ready(ir[2]),
        .flush(flush), .y(y[2]), .out_valid(ov[2]), .out_ready(out_ready), .sel_err(er[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         dut;
        logic [3:0] s;
        logic [7:0] ey;
        logic       eerr;
    } vec_t;

    vec_t tbl [12];

    logic [7:0] mq [$];
    logic       merr;
    logic       acc, pop;
    int         idx;

    initial begin
        // dut 0: N=4 binary, dut 1: N=3 binary, dut 2: N=4 one-hot; d = 44_33_22_11
        tbl[0]  = '{0, 4'd0,    8'h11, 1'b0};
        tbl[1]  = '{0, 4'd2,    8'h33, 1'b0};
        tbl[2]  = '{0, 4'd3,    8'h44, 1'b0};
        tbl[3]  = '{1, 4'd0,    8'h11, 1'b0};
        tbl[4]  = '{1, 4'd2,    8'h33, 1'b0};
        tbl[5]  = '{1, 4'd3,    8'h33, 1'b1};
        tbl[6]  = '{2, 4'b0100, 8'h33, 1'b0};
        tbl[7]  = '{2, 4'b0001, 8'h11, 1'b0};
        tbl[8]  = '{2, 4'b1000, 8'h44, 1'b0};
        tbl[9]  = '{2, 4'b0110, 8'h22, 1'b1};
        tbl[10] = '{2, 4'b0000, 8'h11, 1'b1};
        tbl[11] = '{2, 4'b0100, 8'h33, 1'b1};

        reset = 1'b1; d = '0; s4 = '0; s3 = '0; sh = '0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;

        // Reset: two cycles, in_ready low throughout, high right after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rst_in_ready_low", ir[i], 0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready_high", ir[i], 1);
            chk("rst_out_valid", ov[i], 0);
            chk("rst_y", y[i], 0);
            chk("rst_sel_err", er[i], 0);
        end

        // Vector table: one beat each, checked one cycle after accept.
        d = 32'h44332211;
        @(negedge clk);
        foreach (tbl[r]) begin
            iv[tbl[r].dut] = 1'b1;
            case (tbl[r].dut)
                0:       s4 = tbl[r].s[1:0];
                1:       s3 = tbl[r].s[1:0];
                default: sh = tbl[r].s;
            endcase
            @(negedge clk);
            iv[tbl[r].dut] = 1'b0;
            chk("tbl_out_valid", ov[tbl[r].dut], 1);
            chk("tbl_y", y[tbl[r].dut], tbl[r].ey);
            chk("tbl_sel_err", er[tbl[r].dut], tbl[r].eerr);
        end

        // sel_err survives a flush.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_keeps_sel_err", er[1], 1);
        chk("flush_out_valid", ov[1], 0);

        // Streaming on N=4: one beat per cycle, latency 1.
        for (int k = 0; k < 4; k++) begin
            iv[0] = 1'b1; s4 = 2'(k);
            @(negedge clk);
            chk("stream_y", y[0], 32'h11 * (k + 1));
            chk("stream_out_valid", ov[0], 1);
            chk("stream_in_ready", ir[0], 1);
        end
        iv[0] = 1'b0;
        @(negedge clk);
        chk("stream_drain", ov[0], 0);

        // Backpressure: A then B stalled, then drain in order.
        d = 32'h00005AA5; out_ready = 1'b0;
        iv[0] = 1'b1; s4 = 2'd0;
        @(negedge clk);
        chk("bp_y_a", y[0], 8'hA5);
        chk("bp_in_ready_one", ir[0], 1);
        s4 = 2'd1;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("bp_in_ready_two", ir[0], 0);
        chk("bp_y_held", y[0], 8'hA5);
        @(negedge clk);
        chk("bp_y_held2", y[0], 8'hA5);
        chk("bp_ov_held", ov[0], 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_y_b", y[0], 8'h5A);
        chk("bp_in_ready_back", ir[0], 1);
        @(negedge clk);
        chk("bp_drained", ov[0], 0);

        // Flush in TWO with a beat offered the same cycle.
        out_ready = 1'b0;
        iv[0] = 1'b1; s4 = 2'd0;
        @(negedge clk);
        s4 = 2'd1;
        @(negedge clk);
        chk("fl_two_in_ready", ir[0], 0);
        flush = 1'b1; s4 = 2'd2; d = 32'h00CC5AA5;
        @(negedge clk);
        flush = 1'b0; iv[0] = 1'b0; out_ready = 1'b1;
        chk("fl_two_out_valid", ov[0], 0);
        chk("fl_two_in_ready_back", ir[0], 1);
        chk("fl_two_y_unchanged", y[0], 8'hA5);
        @(negedge clk);
        chk("fl_two_nothing_appears", ov[0], 0);

        // Flush in ONE discards the beat accepted in the same cycle.
        out_ready = 1'b0; d = 32'h00CC5AA5;
        iv[0] = 1'b1; s4 = 2'd0;
        @(negedge clk);
        flush = 1'b1; s4 = 2'd2;
        @(negedge clk);
        flush = 1'b0; iv[0] = 1'b0; out_ready = 1'b1;
        chk("fl_one_out_valid", ov[0], 0);
        chk("fl_one_y_unchanged", y[0], 8'hA5);
        @(negedge clk);
        chk("fl_one_nothing_appears", ov[0], 0);

        // Reset while in TWO.
        out_ready = 1'b0; iv[0] = 1'b1; s4 = 2'd0;
        @(negedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        chk("rst2_in_two", ir[0], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", ov[0], 0);
        chk("rst2_y", y[0], 0);
        chk("rst2_in_ready_low", ir[0], 0);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst2_in_ready_high", ir[0], 1);
        chk("rst2_sel_err_cleared", er[1], 0);

        // Random run on N=3 against a queue model of the buffered beats.
        merr = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 500; c++) begin
            chk("rnd_out_valid", ov[1], mq.size() != 0);
            chk("rnd_in_ready", ir[1], mq.size() < 2);
            if (mq.size() != 0) chk("rnd_y", y[1], mq[0]);
            chk("rnd_sel_err", er[1], merr);
            iv[1]     = 1'($urandom_range(0, 1));
            s3        = 2'($urandom);
            d         = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            acc = iv[1] && (mq.size() < 2);
            pop = (mq.size() != 0) && out_ready;
            idx = (s3 >= 2) ? 2 : int'(s3);
            @(posedge clk);
            if (acc && s3 == 2'd3) merr = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(d[idx*8 +: 8]);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
